// File: rtl/rdata_fifo_refill_sched.sv
// Refill scheduler for the per-channel video read-data FIFOs: round-robin picks a channel with
// FIFO space and spare burst credit, then issues one fixed-length read burst per handshake.
module rdata_fifo_refill_sched #(
  parameter int unsigned CH_NUM     = 3,
  parameter int unsigned LEVEL_W    = 11,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned ADDR_W     = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         ch_en,
  input  logic [CH_NUM*ADDR_W-1:0]  ch_base_addr,
  input  logic [ADDR_W-1:0]         frame_words,
  input  logic [CH_NUM*LEVEL_W-1:0] wr_water_level,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [2:0]                cmd_ch,
  input  logic                      rd_done_valid,
  input  logic [2:0]                rd_done_ch,
  output logic [CH_NUM-1:0]         frame_done,
  output logic                      err_underflow
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;
  localparam int unsigned EW = LEVEL_W + 4;
  localparam logic [ADDR_W-1:0] BurstWords = ADDR_W'(BURST_LEN);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [2:0]        cmd_ch_q, cmd_ch_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        inflight_q [CH_NUM];
  logic [2:0]        inflight_d [CH_NUM];
  logic [ADDR_W-1:0] offset_q [CH_NUM];
  logic [ADDR_W-1:0] offset_d [CH_NUM];
  logic [CH_NUM-1:0] frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic [CH_NUM-1:0] elig;
  logic              grant_found, hi_found;
  logic [2:0]        grant, hi_grant, lo_grant;
  logic              accept;

  // Space check counts both FIFO level and bursts still in flight (deliberately conservative).
  always_comb begin : elig_c
    logic [EW-1:0] need;
    need = '0;
    elig = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      need = EW'(wr_water_level[i*LEVEL_W +: LEVEL_W])
           + (EW'(inflight_q[i]) + EW'(1)) * EW'(BURST_LEN);
      elig[i] = ch_en[i] && (inflight_q[i] < 3'(MAX_OUT)) && (need <= EW'(FIFO_DEPTH));
    end
  end

  // Rotating priority: first eligible at or above rr_ptr, else first eligible from 0.
  always_comb begin
    hi_found    = 1'b0;
    hi_grant    = '0;
    grant_found = 1'b0;
    lo_grant    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (!hi_found && elig[i] && (3'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_grant = 3'(i);
      end
      if (!grant_found && elig[i]) begin
        grant_found = 1'b1;
        lo_grant    = 3'(i);
      end
    end
    grant = hi_found ? hi_grant : lo_grant;
  end

  assign accept = (state_q == StIssue) && cmd_ready;

  always_comb begin
    state_d      = state_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_ch_d     = cmd_ch_q;
    rr_ptr_d     = rr_ptr_q;
    frame_done_d = '0;
    err_d        = err_q;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      inflight_d[i] = inflight_q[i];
      offset_d[i]   = offset_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (grant == 3'(i)) begin
              cmd_addr_d = ch_base_addr[i*ADDR_W +: ADDR_W] + offset_q[i];
            end
          end
          cmd_ch_d = grant;
          state_d  = StIssue;
        end
      end
      default: begin
        if (accept) begin
          state_d  = StIdle;
          rr_ptr_d = (cmd_ch_q == 3'(CH_NUM - 1)) ? 3'd0 : cmd_ch_q + 3'd1;
          for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (cmd_ch_q == 3'(i)) begin
              if (offset_q[i] == frame_words - BurstWords) begin
                offset_d[i]     = '0;
                frame_done_d[i] = 1'b1;
              end else begin
                offset_d[i] = offset_q[i] + BurstWords;
              end
            end
          end
        end
      end
    endcase

    for (int unsigned i = 0; i < CH_NUM; i++) begin
      // A disabled channel restarts its frame, unless its command is already on the bus.
      if (!ch_en[i] && !((state_q == StIssue) && (cmd_ch_q == 3'(i)))) begin
        offset_d[i] = '0;
      end
      if ((accept && (cmd_ch_q == 3'(i))) && !(rd_done_valid && (rd_done_ch == 3'(i)))) begin
        inflight_d[i] = inflight_q[i] + 3'd1;
      end else if (!(accept && (cmd_ch_q == 3'(i))) && rd_done_valid
                   && (rd_done_ch == 3'(i))) begin
        if (inflight_q[i] == 3'd0) begin
          err_d = 1'b1;
        end else begin
          inflight_d[i] = inflight_q[i] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_addr_q   <= '0;
      cmd_ch_q     <= '0;
      rr_ptr_q     <= '0;
      frame_done_q <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        inflight_q[i] <= '0;
        offset_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_ch_q     <= cmd_ch_d;
      rr_ptr_q     <= rr_ptr_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        inflight_q[i] <= inflight_d[i];
        offset_q[i]   <= offset_d[i];
      end
    end
  end

  assign cmd_valid     = (state_q == StIssue);
  assign cmd_addr      = cmd_addr_q;
  assign cmd_ch        = cmd_ch_q;
  assign frame_done    = frame_done_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_rdata_fifo_refill_sched.sv
// Bench for rdata_fifo_refill_sched: directed scenarios plus a randomized run against a
// transaction-level model of the scheduling rules.
module tb_rdata_fifo_refill_sched;

  localparam int CH_NUM     = 3;
  localparam int LEVEL_W    = 11;
  localparam int FIFO_DEPTH = 1024;
  localparam int BURST_LEN  = 64;
  localparam int MAX_OUT    = 2;
  localparam int ADDR_W     = 28;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CH_NUM-1:0]         ch_en;
  logic [CH_NUM*ADDR_W-1:0]  ch_base_addr;
  logic [ADDR_W-1:0]         frame_words;
  logic [CH_NUM*LEVEL_W-1:0] wr_water_level;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [2:0]                cmd_ch;
  logic                      rd_done_valid;
  logic [2:0]                rd_done_ch;
  logic [CH_NUM-1:0]         frame_done;
  logic                      err_underflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [ADDR_W-1:0] base_a [CH_NUM];
  logic [ADDR_W-1:0] acc_addr[$];
  int                acc_ch[$];
  int                acc_cyc[$];

  rdata_fifo_refill_sched #(
    .CH_NUM(CH_NUM), .LEVEL_W(LEVEL_W), .FIFO_DEPTH(FIFO_DEPTH),
    .BURST_LEN(BURST_LEN), .MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_base_addr(ch_base_addr),
    .frame_words(frame_words), .wr_water_level(wr_water_level),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_ch(cmd_ch),
    .rd_done_valid(rd_done_valid), .rd_done_ch(rd_done_ch),
    .frame_done(frame_done), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are logged half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      acc_addr.push_back(cmd_addr);
      acc_ch.push_back(int'(cmd_ch));
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_addr.delete();
    acc_ch.delete();
    acc_cyc.delete();
  endtask

  task automatic set_level(input int c, input int v);
    wr_water_level[c*LEVEL_W +: LEVEL_W] = LEVEL_W'(v);
  endtask

  task automatic set_bases();
    for (int c = 0; c < CH_NUM; c++) begin
      base_a[c] = ADDR_W'($urandom);
      ch_base_addr[c*ADDR_W +: ADDR_W] = base_a[c];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_en = '0; cmd_ready = 1'b0; rd_done_valid = 1'b0; rd_done_ch = '0;
    wr_water_level = '0;
    repeat (3) tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 20 && !cmd_valid; i++) tick();
    n_cmp++;
    if (!cmd_valid) begin
      n_fail++;
      $display("FAIL %s: cmd_valid=%0b required 1 within 20 cycles", name, cmd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '0; cmd_ready = 1'b1; rd_done_valid = 1'b0; rd_done_ch = '0;
    wr_water_level = '0; frame_words = ADDR_W'(BURST_LEN * 4);
    set_bases();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      n_cmp++;
      if ({cmd_valid, frame_done, err_underflow} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: valid=%0b fd=%b err=%0b required all 0",
                 i, cmd_valid, frame_done, err_underflow);
      end
    end
    n_cmp++;
    if (cmd_addr !== '0 || cmd_ch !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_cmd: addr=%h ch=%0d required 0/0", cmd_addr, cmd_ch);
    end
  endtask

  task automatic test_credits();
    do_reset();
    frame_words = ADDR_W'(BURST_LEN * 16);
    ch_en = 3'b001; cmd_ready = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (acc_addr.size() != 2 || acc_addr[0] !== base_a[0]
        || acc_addr[1] !== base_a[0] + ADDR_W'(BURST_LEN)) begin
      n_fail++;
      $display("FAIL credits_two: count=%0d required 2 at base0 and base0+64", acc_addr.size());
    end
    rd_done_valid = 1'b1; rd_done_ch = 3'd0;
    tick();
    rd_done_valid = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (acc_addr.size() != 3 || acc_addr[2] !== base_a[0] + ADDR_W'(2 * BURST_LEN)) begin
      n_fail++;
      $display("FAIL credits_third: count=%0d required 3 with third at base0+128",
               acc_addr.size());
    end
  endtask

  task automatic test_space();
    do_reset();
    frame_words = ADDR_W'(BURST_LEN * 16);
    ch_en = 3'b001; cmd_ready = 1'b1; set_level(0, 961);
    repeat (12) tick();
    n_cmp++;
    if (acc_addr.size() != 0) begin
      n_fail++;
      $display("FAIL space_961: commands=%0d required 0", acc_addr.size());
    end
    set_level(0, 960);
    repeat (12) tick();
    n_cmp++;
    if (acc_addr.size() != 1 || acc_addr[0] !== base_a[0]) begin
      n_fail++;
      $display("FAIL space_960: commands=%0d required 1 at base0", acc_addr.size());
    end
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] a0;
    logic [2:0]        c0;
    int exp_ch [4] = '{0, 1, 2, 0};
    do_reset();
    frame_words = ADDR_W'(BURST_LEN * 16);
    ch_en = 3'b111; cmd_ready = 1'b0;
    wait_valid("rr_first_valid");
    a0 = cmd_addr; c0 = cmd_ch;
    n_cmp++;
    if (c0 !== 3'd0 || a0 !== base_a[0]) begin
      n_fail++;
      $display("FAIL rr_first: ch=%0d addr=%h required 0/%h", c0, a0, base_a[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_addr !== a0 || cmd_ch !== c0) begin
        n_fail++;
        $display("FAIL rr_stall[%0d]: valid=%0b addr=%h ch=%0d required 1/%h/%0d",
                 i, cmd_valid, cmd_addr, cmd_ch, a0, c0);
      end
    end
    cmd_ready = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if (acc_ch.size() < 4) begin
      n_fail++;
      $display("FAIL rr_count: accepts=%0d required at least 4", acc_ch.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (acc_ch[k] != exp_ch[k]
            || acc_addr[k] !== base_a[exp_ch[k]] + ADDR_W'((k == 3) ? BURST_LEN : 0)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: ch=%0d addr=%h required ch %0d", k, acc_ch[k],
                   acc_addr[k], exp_ch[k]);
        end
        if (k > 0) begin
          n_cmp++;
          if (acc_cyc[k] - acc_cyc[k-1] != 2) begin
            n_fail++;
            $display("FAIL rr_rate[%0d]: gap=%0d required 2", k, acc_cyc[k] - acc_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    int prev;
    logic [CH_NUM-1:0] exp_fd;
    int exp_off [4] = '{0, 64, 128, 0};
    do_reset();
    frame_words = ADDR_W'(192);
    ch_en = 3'b001; cmd_ready = 1'b1;
    for (int i = 0; i < 40 && acc_addr.size() < 4; i++) begin
      prev = acc_addr.size();
      tick();
      rd_done_valid = (acc_addr.size() > prev);
      rd_done_ch = 3'd0;
      exp_fd = (acc_addr.size() > prev && acc_addr.size() == 3) ? 3'b001 : 3'b000;
      n_cmp++;
      if (frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL wrap_frame_done[cyc %0d]: got %b required %b", cyc, frame_done, exp_fd);
      end
    end
    tick();
    rd_done_valid = 1'b0;
    n_cmp++;
    if (acc_addr.size() < 4) begin
      n_fail++;
      $display("FAIL wrap_count: accepts=%0d required 4", acc_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (acc_addr[k] !== base_a[0] + ADDR_W'(exp_off[k])) begin
          n_fail++;
          $display("FAIL wrap_addr[%0d]: got %h required %h", k, acc_addr[k],
                   base_a[0] + ADDR_W'(exp_off[k]));
        end
      end
    end
  endtask

  task automatic test_simultaneous_err();
    do_reset();
    frame_words = ADDR_W'(BURST_LEN * 16);
    ch_en = 3'b010; cmd_ready = 1'b0;
    wait_valid("sim_first_valid");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    wait_valid("sim_second_valid");
    cmd_ready = 1'b1; rd_done_valid = 1'b1; rd_done_ch = 3'd1;
    tick();
    cmd_ready = 1'b0; rd_done_valid = 1'b0;
    clear_log();
    cmd_ready = 1'b1;
    repeat (12) tick();
    // inflight[1] still 1: exactly one more credit remains
    n_cmp++;
    if (acc_addr.size() != 1 || acc_addr[0] !== base_a[1] + ADDR_W'(2 * BURST_LEN)) begin
      n_fail++;
      $display("FAIL sim_inflight: extra commands=%0d required 1 at base1+128", acc_addr.size());
    end
    n_cmp++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_no_err: err=%0b required 0", err_underflow);
    end
    rd_done_valid = 1'b1; rd_done_ch = 3'd5;
    tick();
    rd_done_ch = 3'd2;
    tick();
    rd_done_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (err_underflow !== 1'b1) begin
        n_fail++;
        $display("FAIL underflow_sticky[%0d]: err=%0b required 1", i, err_underflow);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: err=%0b required 0 after rst", err_underflow);
    end
  endtask

  task automatic test_random();
    bit                m_issue, pre_issue, acc, dec, inc, found;
    logic [ADDR_W-1:0] m_addr;
    int                m_ch, pre_ch, m_rr, c, fw;
    int                m_infl [CH_NUM];
    int                m_off  [CH_NUM];
    int                lvl    [CH_NUM];
    logic [CH_NUM-1:0] m_fd;
    bit                m_err;
    do_reset();
    set_bases();
    fw = BURST_LEN * int'($urandom_range(1, 4));
    frame_words = ADDR_W'(fw);
    m_issue = 0; m_addr = '0; m_ch = 0; m_rr = 0; m_fd = '0; m_err = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      m_infl[i] = 0; m_off[i] = 0;
    end
    for (int t = 0; t < 3000; t++) begin
      if (t % 16 == 0) ch_en = CH_NUM'($urandom);
      for (int i = 0; i < CH_NUM; i++) begin
        lvl[i] = int'($urandom_range(0, 1100));
        set_level(i, lvl[i]);
      end
      cmd_ready = ($urandom_range(0, 3) != 0);
      rd_done_ch = 3'($urandom_range(0, 7));
      rd_done_valid = ($urandom_range(0, 2) == 0);
      if (int'(rd_done_ch) < CH_NUM && m_infl[rd_done_ch] == 0) rd_done_valid = 1'b0;
      tick();
      // Model the edge just taken, using the inputs that were held across it.
      pre_issue = m_issue; pre_ch = m_ch;
      acc = m_issue && cmd_ready;
      m_fd = '0;
      if (!m_issue) begin
        found = 0;
        for (int k = 0; k < CH_NUM && !found; k++) begin
          c = (m_rr + k) % CH_NUM;
          if (ch_en[c] && m_infl[c] < MAX_OUT
              && lvl[c] + (m_infl[c] + 1) * BURST_LEN <= FIFO_DEPTH) begin
            found = 1; m_issue = 1; m_ch = c;
            m_addr = base_a[c] + ADDR_W'(m_off[c]);
          end
        end
      end else if (acc) begin
        m_issue = 0;
        m_rr = (m_ch + 1) % CH_NUM;
        if (m_off[m_ch] == fw - BURST_LEN) begin
          m_off[m_ch] = 0; m_fd[m_ch] = 1'b1;
        end else begin
          m_off[m_ch] += BURST_LEN;
        end
      end
      for (int i = 0; i < CH_NUM; i++) begin
        inc = acc && pre_ch == i;
        dec = rd_done_valid && int'(rd_done_ch) == i;
        if (dec && !inc && m_infl[i] == 0) m_err = 1;
        else m_infl[i] += int'(inc) - int'(dec);
        if (!ch_en[i] && !(pre_issue && pre_ch == i)) m_off[i] = 0;
      end
      n_cmp++;
      if (cmd_valid !== m_issue || (m_issue && (cmd_addr !== m_addr || int'(cmd_ch) != m_ch))
          || frame_done !== m_fd || err_underflow !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: v=%0b a=%h ch=%0d fd=%b err=%0b required %0b %h %0d %b %0b",
                 t, cmd_valid, cmd_addr, cmd_ch, frame_done, err_underflow,
                 m_issue, m_addr, m_ch, m_fd, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_credits();
    test_space();
    test_round_robin();
    test_wrap();
    test_simultaneous_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rdata_fifo_refill_sched.md
# rdata_fifo_refill_sched

Single-clock refill scheduler for the read-data FIFOs that feed the video output channels.
- Monitors each channel FIFO's write-side water level and in-flight burst count.
- Round-robin arbitrates eligible channels and issues one fixed-length memory read-burst command at a time over a valid/ready handshake.
- Advances a per-channel frame address with wrap-around.
- Sits between the DDR read-command port and the write side of the per-channel read-data FIFOs.

## Interface
Parameters:
- CH_NUM, 3, number of FIFO channels (2..8)
- LEVEL_W, 11, width of each FIFO water-level input (FIFO depth width + 1)
- FIFO_DEPTH, 1024, FIFO capacity in words
- BURST_LEN, 64, words per read burst (power of 2, ≤ FIFO_DEPTH/2)
- MAX_OUT, 2, maximum outstanding bursts per channel (1..7)
- ADDR_W, 28, word-address width

Ports (clock and reset first):
- clk, in, 1, the only clock
- rst, in, 1, synchronous active-high reset
- ch_en, in, CH_NUM, per-channel enable
- ch_base_addr, in, CH_NUM*ADDR_W, packed frame base address per channel (channel i at [i*ADDR_W +: ADDR_W])
- frame_words, in, ADDR_W, frame length in words, common to all channels (multiple of BURST_LEN, ≥ BURST_LEN)
- wr_water_level, in, CH_NUM*LEVEL_W, packed FIFO write-side levels
- cmd_valid, out, 1, read-burst command valid
- cmd_ready, in, 1, memory side accepts command
- cmd_addr, out, ADDR_W, burst start address
- cmd_ch, out, 3, channel index of the command
- rd_done_valid, in, 1, one-cycle pulse: last word of a burst written into the FIFO
- rd_done_ch, in, 3, channel of the completed burst
- frame_done, out, CH_NUM, one-cycle pulse when a channel's last burst of a frame is accepted
- err_underflow, out, 1, sticky; set when rd_done arrives for a channel whose inflight count is 0

## Operation
- Per-channel state:
  - inflight[i], 0..MAX_OUT
  - offset[i], ADDR_W bits
- Eligibility of channel i requires all of:
  - ch_en[i]=1
  - inflight[i] < MAX_OUT
  - level[i] + (inflight[i]+1)*BURST_LEN ≤ FIFO_DEPTH
- Eligibility arithmetic is evaluated at LEVEL_W+4 bits, unsigned, with no truncation.
- Data still in flight may be counted in both level and inflight; this over-reserves space, which is allowed and safe.
- FSM, two states:
  - IDLE: if any channel is eligible, grant the first eligible channel searching upward from rr_ptr (modulo CH_NUM). Register cmd_addr = base[g] + offset[g] and cmd_ch = g, then go to ISSUE. If none is eligible, stay in IDLE.
  - ISSUE: cmd_valid=1. cmd_addr and cmd_ch stay stable until cmd_valid & cmd_ready. On acceptance:
    - inflight[g]++
    - rr_ptr = (g+1) mod CH_NUM
    - if offset[g] = frame_words−BURST_LEN: offset[g]=0 and frame_done[g] pulses; otherwise offset[g] += BURST_LEN
    - return to IDLE
- Dropping ch_en during ISSUE does not withdraw the command; it completes normally.
- While ch_en[i]=0 and the channel is not in ISSUE: offset[i] is held at 0, so the frame restarts from base.
- rd_done_valid decrements inflight[rd_done_ch].
  - Acceptance and done for the same channel in the same cycle: inflight unchanged.
  - Done with inflight=0: count stays 0 and err_underflow is set.
  - rd_done_ch ≥ CH_NUM is ignored.
- rst values:
  - state=IDLE, cmd_valid=0, cmd_addr=0, cmd_ch=0
  - all inflight=0, all offsets=0, rr_ptr=0
  - frame_done=0, err_underflow=0
- rst asserted mid-ISSUE drops cmd_valid on the next edge. The command is lost; the upstream owner flushes the FIFOs.

## Timing
- All outputs are registered.
- Eligible at edge N while in IDLE → cmd_valid=1 from N+1.
- Acceptance at edge M → cmd_valid=0 from M+1. inflight and offset are updated at M+1, and the next IDLE decision uses the updated values. Earliest next cmd_valid is M+2, so the maximum rate is one command per 2 cycles.
- frame_done is high for exactly the cycle after the accepting edge.
- rd_done takes effect on inflight at the following edge.
- Water-level inputs are sampled directly. They come from the same clock domain; no synchroniser is included.

## Test plan
- Reset/idle: rst for 3 cycles, all ch_en=0.
  - Required: cmd_valid=0, frame_done=0, err_underflow=0 throughout.
- Single channel, credits: ch_en=001, level=0, cmd_ready=1, no rd_done.
  - Required: exactly 2 commands at addresses base0 and base0+64, then cmd_valid stays 0.
  - Then one rd_done for ch0 → a third command at base0+128.
- Space limit: ch_en=001, level[0]=961, MAX_OUT=2.
  - Required: no command (961+64 > 1024).
  - Set level=960 → one command issued; then stalls (960+128 > 1024).
- Round robin with backpressure: all 3 channels eligible, cmd_ready low for 5 cycles, then held high.
  - Required: cmd_addr and cmd_ch stable while stalled.
  - Grant order ch0, ch1, ch2, ch0, and one command every 2 cycles.
- Wrap: frame_words=192, ch0 enabled, done returned after each burst.
  - Required: addresses base0 +0, +64, +128; frame_done[0] pulses with the third acceptance; then +0 again.
- Simultaneous events and error:
  - rd_done for ch1 in the same cycle that ch1's command is accepted → inflight[1] unchanged.
  - rd_done for ch2 with inflight=0 → err_underflow=1 and stays 1 until rst.
